// File: rtl/packet_pkg.sv
// packet_pkg: packet format shared by packet_gen and packet_rx.
package packet_pkg;
    localparam int         PKT_W        = 13;
    localparam logic [1:0] DEST_INVALID = 2'd3;
    localparam int         NUM_DEST     = 3;

    typedef struct packed {
        logic [1:0] dest_addr;
        logic [1:0] packet_type;
        logic [7:0] payload;
        logic       eop_flag;
    } packet_t;

    function automatic logic pkt_is_valid(packet_t p);
        return (p.dest_addr != DEST_INVALID) && p.eop_flag;
    endfunction
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with occupancy counter; DEPTH must be a power of two.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign full    = cnt_q == (AW+1)'(DEPTH);
    assign empty   = cnt_q == '0;
    assign count   = cnt_q;
    assign dout    = mem_q[rd_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_d  = do_push ? wr_q + 1'b1 : wr_q;
        rd_d  = do_pop ? rd_q + 1'b1 : rd_q;
        cnt_d = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= din;
    end
endmodule

// File: rtl/packet_rx.sv
// packet_rx: checks incoming packets, buffers good ones and routes the FIFO head
// to one of three destinations; bad packets are dropped and counted.
module packet_rx
    import packet_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                src_valid,
    output logic                src_ready,
    input  logic [PKT_W-1:0]    packet,
    output logic [NUM_DEST-1:0] dst_valid,
    input  logic [NUM_DEST-1:0] dst_ready,
    output logic [1:0]          dst_type,
    output logic [7:0]          dst_payload,
    output logic [CNT_W-1:0]    rx_cnt,
    output logic [CNT_W-1:0]    drop_cnt
);
    packet_t                     in_pkt, head_pkt;
    logic [PKT_W-1:0]            head_raw;
    logic                        full, empty, accept, good, bad, pop;
    logic [$clog2(FIFO_DEPTH):0] occ;
    logic [CNT_W-1:0]            rx_cnt_q, rx_cnt_d, drop_cnt_q, drop_cnt_d;

    assign in_pkt    = packet_t'(packet);
    assign head_pkt  = packet_t'(head_raw);
    assign src_ready = !rst && !full;
    assign accept    = src_valid && src_ready;
    assign good      = accept && pkt_is_valid(in_pkt);
    assign bad       = accept && !pkt_is_valid(in_pkt);
    assign pop       = (occ != '0) && |(dst_valid & dst_ready);

    // Head dest is never 3 since invalid packets never enter the FIFO.
    always_comb begin
        dst_valid   = empty ? '0 : NUM_DEST'(1 << head_pkt.dest_addr);
        dst_type    = empty ? '0 : head_pkt.packet_type;
        dst_payload = empty ? '0 : head_pkt.payload;
        rx_cnt_d    = rx_cnt_q + CNT_W'(good && !(&rx_cnt_q));
        drop_cnt_d  = drop_cnt_q + CNT_W'(bad && !(&drop_cnt_q));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_cnt_q   <= '0;
            drop_cnt_q <= '0;
        end else begin
            rx_cnt_q   <= rx_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign rx_cnt   = rx_cnt_q;
    assign drop_cnt = drop_cnt_q;

    sync_fifo #(.WIDTH(PKT_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (good),
        .din   (packet),
        .pop   (pop),
        .dout  (head_raw),
        .full  (full),
        .empty (empty),
        .count (occ)
    );
endmodule
